// File: rtl/reg_bus_bridge.sv
// Valid/ready front end for the controlling-register bus: one registered access per request.
// Optional address range check enabled by defining REG_BRIDGE_RANGE_CHECK_EN.
module reg_bus_bridge #(
  parameter int                    ADDR_WIDTH  = 33,
  parameter int                    DATA_WIDTH  = 33,
  parameter int                    RDATA_WIDTH = 21,
  parameter int                    COUNT_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = 'hFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [RDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_error,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   write_enable,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   read_enable,
  input  logic [RDATA_WIDTH-1:0] read_data,
  output logic [COUNT_WIDTH-1:0] access_count
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | one-cycle bus access, enables asserted
  // RESP   | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   write_q;
  logic   error_q;
  logic   legal;

`ifdef REG_BRIDGE_RANGE_CHECK_EN
  assign legal = (req_addr <= ADDR_LIMIT);
`else
  assign legal = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      error_q      <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_error    <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      access_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q      <= req_write;
            error_q      <= !legal;
            address      <= req_addr;
            write_data   <= req_wdata;
            // Refused accesses still spend a cycle in ACCESS but never touch the bus.
            write_enable <= req_write && legal;
            read_enable  <= !req_write && legal;
            req_ready    <= 1'b0;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          write_enable <= 1'b0;
          read_enable  <= 1'b0;
          rsp_write    <= write_q;
          rsp_error    <= error_q;
          rsp_rdata    <= (write_q || error_q) ? '0 : read_data;
          if (!error_q) access_count <= access_count + 1'b1;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          write_enable <= 1'b0;
          read_enable  <= 1'b0;
          rsp_valid    <= 1'b0;
          req_ready    <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_bridge.sv
// Directed self-checking bench for reg_bus_bridge; inputs change and outputs are sampled on the falling edge.
module tb_reg_bus_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [32:0] req_addr;
  logic [32:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
  logic [20:0] rsp_rdata;
  logic [32:0] address;
  logic        write_enable, read_enable;
  logic [32:0] write_data;
  logic [20:0] read_data;
  logic [15:0] access_count;

  int n_cmp = 0;
  int n_err = 0;

  reg_bus_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .address(address), .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data), .access_count(access_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and confirm the enables are never both high.
  task automatic step();
    @(negedge clock);
    chk("no_dual_enable", {63'd0, write_enable & read_enable}, 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    read_data = '0;
    #22;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_read_enable", read_enable, 0);
    chk("rst_address", address, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_access_count", access_count, 0);
    @(negedge clock);
    reset = 1'b1;

    // Write 'hAA <- 'h1234
    req_valid = 1'b1; req_write = 1'b1; req_addr = 'hAA; req_wdata = 'h1234; rsp_ready = 1'b1;
    chk("wr_idle_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("wr_we", write_enable, 1);
    chk("wr_re", read_enable, 0);
    chk("wr_addr", address, 'hAA);
    chk("wr_wdata", write_data, 'h1234);
    chk("wr_ready_low", req_ready, 0);
    chk("wr_no_rsp_yet", rsp_valid, 0);
    step();
    chk("wr_we_drop", write_enable, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_write", rsp_write, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_count", access_count, 1);
    step();
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_ready_back", req_ready, 1);
    chk("wr_addr_hold", address, 'hAA);

    // Read 'h55: read_data is 'h1 only during ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 'h55; read_data = 'h7;
    step();
    req_valid = 1'b0;
    read_data = 'h1;
    chk("rd_re", read_enable, 1);
    chk("rd_we", write_enable, 0);
    chk("rd_addr", address, 'h55);
    step();
    read_data = 'h3;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 'h1);
    chk("rd_rsp_write", rsp_write, 0);
    chk("rd_count", access_count, 2);
    step();
    chk("rd_ready_back", req_ready, 1);

    // Back-to-back reads with req_valid held high: accept every third cycle
    req_valid = 1'b1; req_write = 1'b0; req_addr = 'h10; read_data = 'h5;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k % 3 == 1) begin
        chk("b2b_ready_access", req_ready, 0);
        chk("b2b_re_access", read_enable, 1);
      end else if (k % 3 == 2) begin
        chk("b2b_ready_resp", req_ready, 0);
        chk("b2b_rsp_valid", rsp_valid, 1);
        chk("b2b_re_resp", read_enable, 0);
      end else begin
        chk("b2b_ready_idle", req_ready, 1);
        chk("b2b_re_idle", read_enable, 0);
      end
    end
    req_valid = 1'b0;
    chk("b2b_count", access_count, 5);

    // Read with rsp_ready low for 10 cycles while another request waits
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 'h20; read_data = 'h1ABCD;
    step();
    chk("stall_re", read_enable, 1);
    req_write = 1'b1; req_addr = 'h30; req_wdata = 'h99;
    step();
    read_data = 'h0;
    chk("stall_rsp_valid", rsp_valid, 1);
    chk("stall_rdata", rsp_rdata, 'h1ABCD);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_hold_valid", rsp_valid, 1);
      chk("stall_hold_rdata", rsp_rdata, 'h1ABCD);
      chk("stall_ready_low", req_ready, 0);
      chk("stall_no_we", write_enable, 0);
      chk("stall_no_re", read_enable, 0);
    end
    chk("stall_count", access_count, 6);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("stall_release_valid", rsp_valid, 0);
    chk("stall_release_ready", req_ready, 1);
    chk("stall_release_count", access_count, 6);

    // Reset asserted in the middle of an ACCESS cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 'h40; req_wdata = 'h9;
    step();
    req_valid = 1'b0;
    chk("rstmid_we_before", write_enable, 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_we_drop", write_enable, 0);
    chk("rstmid_ready", req_ready, 1);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_count", access_count, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("rstmid_after_ready", req_ready, 1);
    chk("rstmid_after_valid", rsp_valid, 0);
    chk("rstmid_after_count", access_count, 0);

    // Write above ADDR_LIMIT
    req_valid = 1'b1; req_write = 1'b1; req_addr = 'h100; req_wdata = 'h77;
    step();
    req_valid = 1'b0;
`ifdef REG_BRIDGE_RANGE_CHECK_EN
    chk("range_no_we", write_enable, 0);
    chk("range_no_re", read_enable, 0);
    step();
    chk("range_rsp_valid", rsp_valid, 1);
    chk("range_rsp_error", rsp_error, 1);
    chk("range_rsp_rdata", rsp_rdata, 0);
    chk("range_count", access_count, 0);
`else
    chk("range_off_we", write_enable, 1);
    chk("range_off_addr", address, 'h100);
    step();
    chk("range_off_rsp_valid", rsp_valid, 1);
    chk("range_off_rsp_error", rsp_error, 0);
    chk("range_off_count", access_count, 1);
`endif
    step();
    chk("range_ready_back", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
